// File: rtl/inv_s4_lookup.sv
// rtl/inv_s4_lookup.sv - InvSubWord unit whose inverse table is rebuilt from a forward S-box after reset
// Contains the forward S-box (registered, computed from GF(2^8) inverse + affine map) and the top.

module aes_sbox_fwd (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] INV_EXP = 8'hfe;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (INV_EXP[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) out_byte <= 8'h00;
    else       out_byte <= sbox_f(in_byte);
  end
endmodule

module inv_s4_lookup (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        init_done
);
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t      state_q;
  logic [8:0]  cnt_q;
  logic        wr_en_q;
  logic [7:0]  wr_data_q;
  logic        init_done_q;
  logic        out_valid_q;
  logic [31:0] out_word_q;
  logic [7:0]  sbox_out;
  logic [31:0] out_word_d;
  logic        accept;
  logic [7:0]  inv_mem [256];

  aes_sbox_fwd u_sbox (
    .clk      (clk),
    .reset    (reset),
    .in_byte  (cnt_q[7:0]),
    .out_byte (sbox_out)
  );

  // The S-box output lags its input by one cycle, so the write data is the delayed counter.
  always_ff @(posedge clk) begin
    if (wr_en_q && !reset) inv_mem[sbox_out] <= wr_data_q;
  end

  assign out_word_d = {inv_mem[in_word[31:24]], inv_mem[in_word[23:16]],
                       inv_mem[in_word[15:8]],  inv_mem[in_word[7:0]]};
  assign in_ready   = init_done_q & (~out_valid_q | out_ready);
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= 9'd0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'h00;
      init_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!cnt_q[8]) cnt_q <= cnt_q + 9'd1;
          wr_en_q   <= ~cnt_q[8];
          wr_data_q <= cnt_q[7:0];
          if (wr_en_q && wr_data_q == 8'hff) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            out_word_q  <= out_word_d;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign init_done = init_done_q;
endmodule

// File: tb/tb_inv_s4_lookup.sv
// tb/tb_inv_s4_lookup.sv - scoreboard bench for inv_s4_lookup against a table-based inverse S-box model
module tb_inv_s4_lookup;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        init_done;

  inv_s4_lookup dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  inv_tab [256];
  logic [31:0] exp_q [$];
  logic        rand_rdy = 1'b0;
  logic        stall_v = 1'b0;
  logic [31:0] stall_w = 32'h0;

  function automatic logic [7:0] fwd_s(input int b);
    return FWD[2047 - 8 * b -: 8];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] w);
    return {inv_tab[w[31:24]], inv_tab[w[23:16]], inv_tab[w[15:8]], inv_tab[w[7:0]]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and polices stalls.
  always @(negedge clk) begin
    if (reset) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check32("stall_valid", {31'b0, out_valid}, 32'd1);
        check32("stall_frozen", out_word, stall_w);
      end
      if (out_valid && !out_ready) check32("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h required none", out_word);
        end else begin
          check32("out_word", out_word, exp_q.pop_front());
        end
        stall_v = 1'b0;
      end else if (out_valid) begin
        stall_v = 1'b1;
        stall_w = out_word;
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] e, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_word  = w;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        got = 1'b1;
        break;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 required 1 for word %h", w);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Observes cycles 0..257 after release; init_done/in_ready must rise exactly at 257.
  task automatic wait_init();
    for (int c = 0; c <= 257; c++) begin
      @(negedge clk);
      check32("init_done", {31'b0, init_done}, (c >= 257) ? 32'd1 : 32'd0);
      check32("init_in_ready", {31'b0, in_ready}, (c >= 257) ? 32'd1 : 32'd0);
      check32("init_no_valid", {31'b0, out_valid}, 32'd0);
      if (in_valid && in_ready) exp_q.push_back(model(in_word));
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic known_vector(input logic [31:0] w, input logic [31:0] e);
    int waited;
    send(w, e, waited);
    @(negedge clk);
    check32("latency_valid", {31'b0, out_valid}, 32'd1);
    check32("latency_word", out_word, e);
    tick();
  endtask

  initial begin
    int waited;
    int total;
    logic [7:0] b;
    logic [31:0] w;
    logic [31:0] words [4];
    for (int i = 0; i < 256; i++) inv_tab[fwd_s(i)] = 8'(i);

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check32("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check32("rst_out_word", out_word, 32'd0);
    check32("rst_init_done", {31'b0, init_done}, 32'd0);
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    in_word  = $urandom;
    wait_init();
    repeat (2) tick();

    known_vector(32'h637c1600, 32'h0001ff52);
    known_vector(32'hed000000, 32'h53525252);

    // Round trip through forward S-box, same byte in every lane then rotating lanes
    total = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send({4{fwd_s(i)}}, {4{b}}, waited);
      total += waited;
    end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send({fwd_s(32'(b)), fwd_s(32'(8'(b + 8'd64))), fwd_s(32'(8'(b + 8'd128))), fwd_s(32'(8'(b + 8'd192)))},
           {b, 8'(b + 8'd64), 8'(b + 8'd128), 8'(b + 8'd192)}, waited);
      total += waited;
    end
    check32("full_rate", 32'(total), 32'd0);
    repeat (2) tick();

    // Backpressure: out_ready low for 3 cycles after the first result
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    total = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(words[i], model(words[i]), waited);
          total += waited;
        end
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    check32("bp_wait_cycles", 32'(total), 32'd3);
    repeat (3) tick();

    // Random words with random downstream readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      send(w, model(w), waited);
    end
    rand_rdy = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // Mid-sweep reset
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init();
    known_vector(32'h637c1600, 32'h0001ff52);

    // Reset while a result is stalled
    out_ready = 1'b0;
    w = $urandom;
    send(w, model(w), waited);
    @(negedge clk);
    check32("pend_valid", {31'b0, out_valid}, 32'd1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check32("pend_rst_valid", {31'b0, out_valid}, 32'd0);
    check32("pend_rst_word", out_word, 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    wait_init();
    repeat (3) tick();
    known_vector(32'hed000000, 32'h53525252);
    repeat (3) tick();

    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
